// File: rtl/my_regfile2_pkg.sv
// Shared constants and FSM state type for the my_regfile2 register file.
// No logic; imported by the interface, the sweep sequencer and the top.
package regfile_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_DEPTH = 16;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_t;

endpackage

// File: rtl/my_regfile2_if.sv
// Register-file access bundle: two read ports, one write port, sweep request/busy.
// Slave side is the register file; master side is the datapath driving it.
interface my_regfile2_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] ra1;
    logic [WIDTH-1:0]  rd1;
    logic [ADDR_W-1:0] ra2;
    logic [WIDTH-1:0]  rd2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;
    logic              init_req;
    logic              busy;

    modport master (
        output ra1, ra2, we, wa, wd, init_req,
        input  rd1, rd2, busy
    );

    modport slave (
        input  ra1, ra2, we, wa, wd, init_req,
        output rd1, rd2, busy
    );

endinterface

// File: rtl/my_regfile2_init_seq.sv
// Re-initialisation sequencer: walks cnt 0..DEPTH-1 writing rf[cnt] <= cnt.
// Latency: busy rises the cycle after init_req, stays high exactly DEPTH cycles.
// Backpressure: none; init_req is ignored while busy (no restart, no queueing).
module my_regfile2_init_seq
    import regfile_pkg::*;
#(
    parameter int  WIDTH  = RF_WIDTH,
    parameter int  DEPTH  = RF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    output logic              busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic [WIDTH-1:0]  sweep_data
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    rf_state_t         state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RF_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Terminal test is an explicit compare so non-wrapping depths stay correct.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sweep_we  = 1'b0;
        case (state)
            RF_IDLE: begin
                if (init_req) begin
                    state_nxt = RF_SWEEP;
                    cnt_nxt   = '0;
                end
            end
            RF_SWEEP: begin
                sweep_we = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = RF_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
        endcase
    end

    assign busy       = (state == RF_SWEEP);
    assign sweep_addr = cnt;
    assign sweep_data = WIDTH'(cnt);

endmodule

// File: rtl/my_regfile2.sv
// CPU GPR file: 2 async read ports, 1 sync write port, reset/sweep load rf[i]=i.
// Latency: reads 0 cycles; writes visible next cycle (same cycle with MY_REGFILE2_WRITE_BYPASS_EN).
// Backpressure: while busy the user write port is dropped, not stalled or queued.
module my_regfile2
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    my_regfile2_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  rf [DEPTH];
    logic              busy;
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic [WIDTH-1:0]  sweep_data;
    logic              user_we;

    my_regfile2_init_seq #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_init_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_req   (bus.init_req),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .sweep_data (sweep_data)
    );

    assign user_we  = bus.we & ~busy;
    assign bus.busy = busy;

    // Reset reloads the whole array, so it also cleans up an aborted sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= WIDTH'(i);
            end
        end else if (sweep_we) begin
            rf[sweep_addr] <= sweep_data;
        end else if (user_we) begin
            rf[bus.wa] <= bus.wd;
        end
    end

    always_comb begin
        bus.rd1 = rf[bus.ra1];
        bus.rd2 = rf[bus.ra2];
`ifdef MY_REGFILE2_WRITE_BYPASS_EN
        if (user_we && (bus.wa == bus.ra1)) bus.rd1 = bus.wd;
        if (user_we && (bus.wa == bus.ra2)) bus.rd2 = bus.wd;
`endif
    end

endmodule

// File: tb/tb_my_regfile2.sv
// Bench for my_regfile2: 16x16 and 8x32 instances, table vectors, corner sequences,
// and random traffic against an array model; honours MY_REGFILE2_WRITE_BYPASS_EN.
module tb_my_regfile2;
    import regfile_pkg::*;

`ifdef MY_REGFILE2_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    my_regfile2_if #(.WIDTH(16), .DEPTH(16)) ifa ();
    my_regfile2_if #(.WIDTH(8),  .DEPTH(32)) ifb ();

    my_regfile2 #(.WIDTH(16), .DEPTH(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    my_regfile2 #(.WIDTH(8),  .DEPTH(32)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: array contents plus position of an in-flight sweep (-1 = none).
    logic [15:0] m [16];
    int          spos;

    typedef struct {
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [3:0] r1, input logic [3:0] r2, input logic w,
                           input logic [3:0] a, input logic [15:0] d, input logic ir);
        ifa.ra1 = r1; ifa.ra2 = r2; ifa.we = w; ifa.wa = a; ifa.wd = d; ifa.init_req = ir;
    endtask

    task automatic drive_b(input logic [4:0] r1, input logic w, input logic [4:0] a,
                           input logic [7:0] d, input logic ir);
        ifb.ra1 = r1; ifb.ra2 = 5'd0; ifb.we = w; ifb.wa = a; ifb.wd = d; ifb.init_req = ir;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = 16'(i);
        spos = -1;
    endtask

    task automatic model_edge(input logic rs, input logic w, input logic [3:0] a,
                              input logic [15:0] d, input logic ir);
        if (!rs) begin
            model_reset();
        end else if (spos >= 0) begin
            m[spos] = 16'(spos);
            spos = (spos == 15) ? -1 : spos + 1;
        end else begin
            if (w) m[a] = d;
            if (ir) spos = 0;
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [3:0] ra, input logic w,
                                             input logic [3:0] a, input logic [15:0] d);
        if (BYP && spos < 0 && w && a == ra) return d;
        return m[ra];
    endfunction

    initial begin
        int cnt;
        bit fell;
        logic [3:0]  r1, r2, a;
        logic [15:0] d;
        logic        w, ir, rs;

        rst_n = 1'b0;
        drive_a(4'd0, 4'd0, 1'b0, 4'd0, 16'd0, 1'b0);
        drive_b(5'd0, 1'b0, 5'd0, 8'd0, 1'b0);
        tick();
        rst_n = 1'b1;

        // Reset contents, both geometries.
        for (int i = 0; i < 16; i++) begin
            drive_a(4'(i), 4'(15 - i), 1'b0, 4'd0, 16'd0, 1'b0);
            #2;
            chk("reset_rd1", 32'(ifa.rd1), 32'(i));
            chk("reset_busy", 32'(ifa.busy), 32'd0);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            drive_b(5'(i), 1'b0, 5'd0, 8'd0, 1'b0);
            #2;
            chk("b_reset_rd1", 32'(ifb.rd1), 32'(i));
            tick();
        end

        // Write/read and same-cycle hazard table.
        tbl[0] = '{4'd0, 4'd15, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h000F};
        tbl[1] = '{4'd5, 4'd6,  1'b1, 4'd5, 16'hBEEF, BYP ? 16'hBEEF : 16'h0005, 16'h0006};
        tbl[2] = '{4'd5, 4'd5,  1'b0, 4'd0, 16'h0000, 16'hBEEF, 16'hBEEF};
        tbl[3] = '{4'd5, 4'd6,  1'b0, 4'd0, 16'h0000, 16'hBEEF, 16'h0006};
        tbl[4] = '{4'd3, 4'd4,  1'b1, 4'd3, 16'h1234, BYP ? 16'h1234 : 16'h0003, 16'h0004};
        tbl[5] = '{4'd3, 4'd3,  1'b0, 4'd0, 16'h0000, 16'h1234, 16'h1234};
        tbl[6] = '{4'd7, 4'd3,  1'b1, 4'd3, 16'h5555, 16'h0007, BYP ? 16'h5555 : 16'h1234};
        tbl[7] = '{4'd3, 4'd5,  1'b0, 4'd0, 16'h0000, 16'h5555, 16'hBEEF};
        for (int k = 0; k < 8; k++) begin
            drive_a(tbl[k].ra1, tbl[k].ra2, tbl[k].we, tbl[k].wa, tbl[k].wd, 1'b0);
            #2;
            chk($sformatf("tbl%0d_rd1", k), 32'(ifa.rd1), 32'(tbl[k].e1));
            chk($sformatf("tbl%0d_rd2", k), 32'(ifa.rd2), 32'(tbl[k].e2));
            chk($sformatf("tbl%0d_busy", k), 32'(ifa.busy), 32'd0);
            tick();
        end

        // Sweep: fill with FFFF, pulse init, dropped write at cycle 8, retrigger at cycle 5.
        for (int i = 0; i < 16; i++) begin
            drive_a(4'd0, 4'd0, 1'b1, 4'(i), 16'hFFFF, 1'b0);
            tick();
        end
        drive_a(4'd9, 4'd9, 1'b0, 4'd0, 16'd0, 1'b1);
        #2;
        chk("sweep_pre_busy", 32'(ifa.busy), 32'd0);
        chk("sweep_pre_fill", 32'(ifa.rd1), 32'hFFFF);
        tick();
        cnt  = 0;
        fell = 1'b0;
        for (int c = 0; c < 40 && !fell; c++) begin
            drive_a(4'd0, 4'd0, 1'b0, 4'd0, 16'd0, c == 5);
            if (c == 8) drive_a(4'd2, 4'd8, 1'b1, 4'd2, 16'hAAAA, 1'b0);
            #2;
            if (c == 0) chk("sweep_busy_rise", 32'(ifa.busy), 32'd1);
            if (c == 8) begin
                chk("sweep_no_bypass", 32'(ifa.rd1), 32'h0002);
                chk("sweep_partial", 32'(ifa.rd2), 32'hFFFF);
            end
            if (ifa.busy) cnt++;
            else if (cnt > 0) fell = 1'b1;
            tick();
        end
        chk("sweep_busy_len", 32'(cnt), 32'd16);
        for (int i = 0; i < 16; i++) begin
            drive_a(4'(i), 4'(15 - i), 1'b0, 4'd0, 16'd0, 1'b0);
            #2;
            chk("sweep_after_rd1", 32'(ifa.rd1), 32'(i));
            chk("sweep_after_rd2", 32'(ifa.rd2), 32'(15 - i));
            tick();
        end

        // Reset at sweep cycle 4 aborts the sweep and reloads unreached entries.
        drive_a(4'd0, 4'd0, 1'b1, 4'd10, 16'hFFFF, 1'b0);
        tick();
        drive_a(4'd0, 4'd0, 1'b0, 4'd0, 16'd0, 1'b1);
        tick();
        drive_a(4'd10, 4'd0, 1'b0, 4'd0, 16'd0, 1'b0);
        for (int c = 0; c < 4; c++) tick();
        #2;
        chk("midrst_busy_before", 32'(ifa.busy), 32'd1);
        chk("midrst_unswept", 32'(ifa.rd1), 32'hFFFF);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        chk("midrst_busy", 32'(ifa.busy), 32'd0);
        for (int i = 0; i < 16; i++) begin
            drive_a(4'(i), 4'd0, 1'b0, 4'd0, 16'd0, 1'b0);
            #1;
            chk("midrst_rd1", 32'(ifa.rd1), 32'(i));
        end
        tick();

        // Randomised traffic against the model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 500; n++) begin
            r1 = 4'($urandom_range(0, 15));
            r2 = 4'($urandom_range(0, 15));
            w  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? r1 : 4'($urandom_range(0, 15));
            d  = 16'($urandom);
            ir = ($urandom_range(0, 24) == 0);
            rs = ($urandom_range(0, 149) != 0);
            drive_a(r1, r2, w, a, d, ir);
            rst_n = rs;
            #2;
            chk("rand_rd1", 32'(ifa.rd1), 32'(model_rd(r1, w, a, d)));
            chk("rand_rd2", 32'(ifa.rd2), 32'(model_rd(r2, w, a, d)));
            chk("rand_busy", 32'(ifa.busy), 32'(spos >= 0));
            tick();
            model_edge(rs, w, a, d, ir);
        end
        rst_n = 1'b1;
        drive_a(4'd0, 4'd0, 1'b0, 4'd0, 16'd0, 1'b0);

        // 8x32 geometry: sweep length and reload of an overwritten entry.
        drive_b(5'd20, 1'b1, 5'd20, 8'hFF, 1'b0);
        tick();
        drive_b(5'd20, 1'b0, 5'd0, 8'd0, 1'b1);
        #2;
        chk("b_write", 32'(ifb.rd1), 32'hFF);
        tick();
        drive_b(5'd20, 1'b0, 5'd0, 8'd0, 1'b0);
        cnt  = 0;
        fell = 1'b0;
        for (int c = 0; c < 100 && !fell; c++) begin
            #2;
            if (ifb.busy) cnt++;
            else fell = 1'b1;
            tick();
        end
        chk("b_sweep_len", 32'(cnt), 32'd32);
        for (int i = 0; i < 32; i++) begin
            drive_b(5'(i), 1'b0, 5'd0, 8'd0, 1'b0);
            #1;
            chk("b_sweep_after", 32'(ifb.rd1), 32'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/my_regfile2.md
Name: my_regfile2

Overview:
- Parametrised successor to the single-read-port, initialised 16x16 register file.
- Adds two asynchronous read ports, one synchronous write port and a synchronous active-low reset that loads every entry with its own index.
- Adds a request-driven re-initialisation sweep, one entry per cycle, with a busy flag.
- Sits in the datapath as the CPU general-purpose register file.

Parameters:
- WIDTH, 16, data bits per register.
- DEPTH, 16, number of registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address bits; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ra1  input  ADDR_W  read address, port 1.
- rd1  output  WIDTH  read data, port 1; combinational rf[ra1].
- ra2  input  ADDR_W  read address, port 2.
- rd2  output  WIDTH  read data, port 2; combinational rf[ra2].
- we  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  WIDTH  write data.
- init_req  input  1  starts the re-initialisation sweep (single-cycle pulse or level).
- busy  output  1  high while the sweep runs.

Behaviour:
- Reset:
  - Rising edge with rst_n=0: every rf[i] <= i, zero-extended or truncated to WIDTH.
  - State <= IDLE, sweep counter <= 0, busy <= 0.
  - Reset has priority over all other inputs, including mid-sweep (sweep aborted, full array reloaded).
- Reads:
  - rd1 and rd2 are purely combinational from the array, zero latency.
  - Both ports may address the same entry.
  - After reset, rdN == raN.
- Writes:
  - In IDLE with we=1: rf[wa] <= wd at the edge. Visible on rd ports from the following cycle (see optional feature).
  - we with wa equal to either read address in the same cycle: read returns the old value.
- FSM, two states:
  - IDLE: busy=0. init_req=1 -> SWEEP with cnt=0. A we in the same cycle as init_req is still performed.
  - SWEEP: busy=1. Each edge writes rf[cnt] <= cnt and increments cnt.
  - When cnt==DEPTH-1: that entry is written, then -> IDLE with cnt <= 0.
  - The sweep takes exactly DEPTH cycles; busy is high for DEPTH cycles starting the cycle after the request.
- While busy:
  - we is ignored; writes are dropped, not queued.
  - init_req is ignored; no restart.
  - Reads stay live and show partially swept contents.
- busy is registered; no combinational path from inputs to busy.
- Counter wrap: cnt is ADDR_W bits. The terminal test is cnt==DEPTH-1, not overflow.

Optional Feature:
- Macro: MY_REGFILE2_WRITE_BYPASS_EN.
- Defined: in IDLE, if we=1 and wa==raN, rdN = wd combinationally in the same cycle (per port independently). No bypass while busy. The array write is unchanged.
- Undefined: reads always return array contents; the new value appears the cycle after the write.

Decomposition:
- Shared package regfile_pkg holds:
  - Default constants RF_WIDTH=16 and RF_DEPTH=16.
  - State enum rf_state_t {RF_IDLE, RF_SWEEP}.
- Natural sub-module: my_regfile2_init_seq, containing the FSM, sweep counter and busy. It outputs sweep_we, sweep_addr and sweep_data, which a write mux in the top level selects over the user write port.

Test Plan:
- Reset: hold rst_n=0 for 1 edge, sweep ra1 over 0..15 -> rd1==ra1 each; busy==0.
- Write/read: we=1, wa=5, wd=16'hBEEF; next cycle ra1=5, ra2=5 -> both read 16'hBEEF; ra2=6 -> 16'h0006.
- Same-cycle hazard: we=1, wa=3, wd=16'h1234, ra1=3. Without macro rd1==16'h0003 that cycle; with macro rd1==16'h1234. Next cycle 16'h1234 in both builds.
- Sweep: write 16'hFFFF to all 16 entries, then 1-cycle init_req:
  - busy high for exactly 16 cycles.
  - we=1, wa=2, wd=16'hAAAA issued in sweep cycle 8 is dropped.
  - After busy falls, rfi==i for all i.
  - A second init_req mid-sweep does not extend busy.
- Reset mid-sweep: rst_n=0 at sweep cycle 4 -> next cycle busy==0 and all entries equal their index.
- Parameter variant: WIDTH=8, DEPTH=32. Reset gives rd1==ra1 for 0..31, and the sweep takes 32 cycles.
